// File: rtl/fifo_ram_drain.sv
// fifo_ram_drain: moves words from a show-ahead-less FIFO into a RAM,
// one word per two cycles, with stop-at-full or wrap addressing.
module fifo_ram_drain #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int RAM_DEPTH = 1024
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              mode_i,
   input  logic [ADDR_W:0]   frame_len_i,
   input  logic              rdempty_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              rdreq_o,
   output logic              wren_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W:0]   word_count_o,
   output logic              done_o,
   output logic              full_o,
   output logic              overflow_o
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WRITE,
      FULL
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(RAM_DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(RAM_DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]     cnt_inc;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic                seen_q, seen_d;
   logic                frame_ok;
   logic                have_word;

   // Saturating word counter value after one more write
   always_comb begin
      cnt_inc = cnt_q;
      if (cnt_q != DEPTH_C) begin
         cnt_inc = cnt_q + 1'b1;
      end
   end

   assign frame_ok  = (frame_len_i != '0) && (frame_len_i <= DEPTH_C);
   assign have_word = enable_i && !rdempty_i;

   // Next-state, address, counter and flag logic; clear wins over all
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      seen_d  = seen_q;
      if (clear_i) begin
         state_d = IDLE;
         addr_d  = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         seen_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (have_word) begin
                  state_d = REQ;
               end
            end
            REQ: begin
               state_d = WRITE;
            end
            WRITE: begin
               cnt_d = cnt_inc;
               if (addr_q == LAST_A) begin
                  addr_d = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
               if (mode_i && (addr_q == LAST_A)) begin
                  ovf_d = 1'b1;
               end
               if (frame_ok && !seen_q &&
                   (cnt_inc == frame_len_i) &&
                   (cnt_q != frame_len_i)) begin
                  done_d = 1'b1;
                  seen_d = 1'b1;
               end
               if (!mode_i && (cnt_inc == DEPTH_C)) begin
                  state_d = FULL;
                  addr_d  = '0;
               end else if (have_word) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
            FULL: begin
               addr_d = '0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         seen_q  <= seen_d;
      end
   end

   assign rdreq_o      = (state_q == REQ);
   assign wren_o       = (state_q == WRITE);
   assign full_o       = (state_q == FULL);
   assign addr_o       = addr_q;
   assign data_o       = data_i;
   assign word_count_o = cnt_q;
   assign done_o       = done_q;
   assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fifo_ram_drain.sv
// tb_fifo_ram_drain: directed scenarios with a FIFO model feeding the
// DUT and a scoreboard checking every RAM write.
module tb_fifo_ram_drain;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 12;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          enable_i;
   logic          clear_i;
   logic          mode_i;
   logic [AW:0]   frame_len_i;
   logic          rdempty_i;
   logic [DW-1:0] data_i;
   logic          rdreq_o;
   logic          wren_o;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] data_o;
   logic [AW:0]   word_count_o;
   logic          done_o;
   logic          full_o;
   logic          overflow_o;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] fifo[$];

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int done_at = 0;
   logic done_prev = 1'b0;
   logic prev_rdreq = 1'b0;
   logic prev_wren = 1'b0;

   fifo_ram_drain #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .RAM_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .enable_i(enable_i),
      .clear_i(clear_i),
      .mode_i(mode_i),
      .frame_len_i(frame_len_i),
      .rdempty_i(rdempty_i),
      .data_i(data_i),
      .rdreq_o(rdreq_o),
      .wren_o(wren_o),
      .addr_o(addr_o),
      .data_o(data_o),
      .word_count_o(word_count_o),
      .done_o(done_o),
      .full_o(full_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_w(int a, logic [DW-1:0] d);
      exp_t e;
      e.a = AW'(a);
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic cycles(int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_clear();
      @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      wr_cnt = 0;
   endtask

   // FIFO model: 1-cycle read latency, data presented after rdreq
   initial begin
      data_i = '0;
      rdempty_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (rdreq_o && fifo.size() > 0) begin
            data_i = fifo.pop_front();
         end
         rdempty_i = (fifo.size() == 0);
      end
   end

   // Monitor: every RAM write is popped against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (wren_o) begin
            check("seq_rdreq_before_wren", 64'(prev_rdreq), 64'd1);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                        addr_o, data_o);
            end else begin
               e = sb.pop_front();
               check("write_addr", 64'(addr_o), 64'(e.a));
               check("write_data", 64'(data_o), 64'(e.d));
            end
            wr_cnt++;
         end
         if (done_o) begin
            done_cnt++;
            done_at = wr_cnt;
            done_prev = prev_wren;
         end
         prev_rdreq = rdreq_o;
         prev_wren = wren_o;
      end
   end

   initial begin
      int k;
      bit hit;
      reset_i = 1'b1;
      enable_i = 1'b0;
      clear_i = 1'b0;
      mode_i = 1'b0;
      frame_len_i = '0;
      cycles(2);
      check("rst_rdreq", 64'(rdreq_o), 64'd0);
      check("rst_wren", 64'(wren_o), 64'd0);
      check("rst_addr", 64'(addr_o), 64'd0);
      check("rst_count", 64'(word_count_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_full", 64'(full_o), 64'd0);
      check("rst_ovf", 64'(overflow_o), 64'd0);
      reset_i = 1'b0;
      cycles(1);

      // three words, stop mode
      for (int i = 0; i < 3; i++) begin
         fifo.push_back(32'hA0 + i);
         expect_w(i, 32'hA0 + i);
      end
      enable_i = 1'b1;
      cycles(14);
      check("s1_count", 64'(word_count_o), 64'd3);
      check("s1_sb_empty", 64'(sb.size()), 64'd0);
      check("s1_idle_rdreq", 64'(rdreq_o), 64'd0);
      check("s1_idle_wren", 64'(wren_o), 64'd0);

      // stop at full
      enable_i = 1'b0;
      do_clear();
      check("clr_addr", 64'(addr_o), 64'd0);
      check("clr_count", 64'(word_count_o), 64'd0);
      for (int i = 0; i < 14; i++) begin
         fifo.push_back(32'hB00 + i);
         if (i < DEPTH) expect_w(i, 32'hB00 + i);
      end
      enable_i = 1'b1;
      cycles(40);
      check("s2_full", 64'(full_o), 64'd1);
      check("s2_addr", 64'(addr_o), 64'd0);
      check("s2_count", 64'(word_count_o), 64'd12);
      check("s2_fifo_left", 64'(fifo.size()), 64'd2);
      check("s2_sb_empty", 64'(sb.size()), 64'd0);
      check("s2_no_rdreq", 64'(rdreq_o), 64'd0);
      enable_i = 1'b0;
      do_clear();
      check("s2_clr_full", 64'(full_o), 64'd0);
      check("s2_clr_addr", 64'(addr_o), 64'd0);
      check("s2_clr_count", 64'(word_count_o), 64'd0);
      fifo.delete();
      cycles(2);

      // wrap mode
      mode_i = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         fifo.push_back(32'hC00 + i);
         expect_w(i % DEPTH, 32'hC00 + i);
      end
      enable_i = 1'b1;
      cycles(40);
      check("s3_ovf", 64'(overflow_o), 64'd1);
      check("s3_count", 64'(word_count_o), 64'd12);
      check("s3_addr", 64'(addr_o), 64'd2);
      check("s3_full", 64'(full_o), 64'd0);
      check("s3_sb_empty", 64'(sb.size()), 64'd0);
      check("s3_no_done", 64'(done_cnt), 64'd0);
      enable_i = 1'b0;
      do_clear();
      check("s3_clr_ovf", 64'(overflow_o), 64'd0);
      mode_i = 1'b0;

      // frame detection
      frame_len_i = 5'd5;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         fifo.push_back(32'hD00 + i);
         expect_w(i, 32'hD00 + i);
      end
      enable_i = 1'b1;
      cycles(40);
      check("s4_done_cnt", 64'(done_cnt), 64'd1);
      check("s4_done_at", 64'(done_at), 64'd5);
      check("s4_done_after_wr", 64'(done_prev), 64'd1);
      check("s4_full", 64'(full_o), 64'd1);
      check("s4_sb_empty", 64'(sb.size()), 64'd0);
      enable_i = 1'b0;
      do_clear();
      frame_len_i = '0;
      check("s4_clr_done", 64'(done_o), 64'd0);

      // FIFO runs dry, then refills
      for (int i = 0; i < 2; i++) begin
         fifo.push_back(32'hE00 + i);
         expect_w(i, 32'hE00 + i);
      end
      enable_i = 1'b1;
      cycles(10);
      check("s5_idle_rdreq", 64'(rdreq_o), 64'd0);
      check("s5_idle_wren", 64'(wren_o), 64'd0);
      check("s5_count_a", 64'(word_count_o), 64'd2);
      for (int i = 2; i < 4; i++) begin
         fifo.push_back(32'hE00 + i);
         expect_w(i, 32'hE00 + i);
      end
      cycles(10);
      check("s5_count_b", 64'(word_count_o), 64'd4);
      check("s5_addr", 64'(addr_o), 64'd4);
      check("s5_sb_empty", 64'(sb.size()), 64'd0);

      // reset during REQ
      enable_i = 1'b0;
      do_clear();
      fifo.push_back(32'hF00);
      fifo.push_back(32'hF01);
      expect_w(0, 32'hF01);
      fifo.push_back(32'hF02);
      expect_w(1, 32'hF02);
      cycles(1);
      enable_i = 1'b1;
      hit = 1'b0;
      for (k = 0; k < 10 && !hit; k++) begin
         @(negedge clk_i);
         if (rdreq_o) hit = 1'b1;
      end
      check("s6_saw_rdreq", 64'(hit), 64'd1);
      #1 reset_i = 1'b1;
      #1;
      check("s6_rst_rdreq", 64'(rdreq_o), 64'd0);
      check("s6_rst_wren", 64'(wren_o), 64'd0);
      check("s6_rst_addr", 64'(addr_o), 64'd0);
      check("s6_rst_count", 64'(word_count_o), 64'd0);
      cycles(2);
      check("s6_hold_wren", 64'(wren_o), 64'd0);
      reset_i = 1'b0;
      cycles(14);
      check("s6_count", 64'(word_count_o), 64'd2);
      check("s6_sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
